// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - default constants, channel state type and width helper for debounce_bank
package debounce_pkg;

    localparam int DEF_STABLE_COUNT = 50;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_REPEAT_DELAY = 400;
    localparam int DEF_REPEAT_RATE  = 100;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } ch_state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced button: synchroniser, stability counter, edge events
// Optional auto-repeat on press_o when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef DEBOUNCE_BANK_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst_L,
    input  logic tick_i,
    input  logic button_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int            CW       = clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    ch_state_e              state_q;
    ch_state_e              state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   accept;
    logic                   press_evt;
    logic                   release_evt;
    logic                   press_next;
    logic                   press_q;
    logic                   release_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sync_q    <= '0;
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], button_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_next;
            release_q <= release_evt;
        end
    end

    // Any agreeing sample restarts the window, so a lone glitch cannot accumulate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sync_lvl == state_o) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q == CNT_LAST)) begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = (state_q == STABLE_HI) ? STABLE_LO : STABLE_HI;
        end else if (tick_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_evt   = accept && (state_q == STABLE_LO);
    assign release_evt = accept && (state_q == STABLE_HI);

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW         = clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          rfirst_q;
    logic          rfirst_d;
    logic          rep_pulse;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end

    // rfirst_q selects the initial delay versus the steady repeat period.
    always_comb begin
        rcnt_d    = rcnt_q;
        rfirst_d  = rfirst_q;
        rep_pulse = 1'b0;
        if ((state_q == STABLE_LO) || accept) begin
            rcnt_d   = '0;
            rfirst_d = 1'b0;
        end else if (tick_i) begin
            if (rcnt_q == (rfirst_q ? RATE_LAST : DELAY_LAST)) begin
                rep_pulse = 1'b1;
                rcnt_d    = '0;
                rfirst_d  = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    assign press_next = press_evt | rep_pulse;
`else
    assign press_next = press_evt;
`endif

    assign state_o   = (state_q == STABLE_HI);
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - CHANNELS-wide debouncer for keypad/fire buttons with registered any_o
// Auto-repeat on press_o is built only when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef DEBOUNCE_BANK_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
    input  logic                clk,
    input  logic                rst_L,
    input  logic                tick_i,
    input  logic [CHANNELS-1:0] button_i,
    output logic [CHANNELS-1:0] state_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic                any_o
);

    logic any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT(STABLE_COUNT),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_BANK_REPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_ch (
            .clk      (clk),
            .rst_L    (rst_L),
            .tick_i   (tick_i),
            .button_i (button_i[i]),
            .state_o  (state_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |state_o;
        end
    end

    assign any_o = any_q;

endmodule
